rd_ptr_ctrl: RTL and testbench

Parametrised read-side pointer controller for the async FIFO, the successor to the fixed 16-entry read pointer block. It lives entirely in the read clock domain. It advances the binary and Gray read pointers and drives the RAM read address. From the synchronised Gray write pointer it produces a registered empty flag, an almost-empty flag, a fill-level count and an underflow pulse.

---
 rtl/rd_ptr_ctrl.sv | 55 +++++
 tb/tb_rd_ptr_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: read-domain pointer controller for an async FIFO, with empty, almost-empty, fill-level and underflow flags
module rd_ptr_ctrl #(
    parameter int ADDR_W = 4,
    parameter int AE_TH  = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   g_wrptr_sync,
    output logic [ADDR_W:0]   b_rdptr,
    output logic [ADDR_W:0]   g_rdptr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);
    localparam logic [ADDR_W:0] AE_V = AE_TH[ADDR_W:0];
    logic [ADDR_W:0] r_b_rdptr, r_g_rdptr, r_rd_count;
    logic            r_empty, r_almost_empty, r_underflow;
    logic            w_rd_ok;
    logic [ADDR_W:0] w_b_next, w_g_next, w_bin, w_cnt_next;
    assign w_rd_ok    = rd_en & ~r_empty;
    assign w_b_next   = r_b_rdptr + {{ADDR_W{1'b0}}, w_rd_ok};
    assign w_g_next   = (w_b_next >> 1) ^ w_b_next;
    // each binary bit is the XOR of all Gray bits from the MSB down to it
    for (genvar i = 0; i <= ADDR_W; i++) begin : g_dec
        assign w_bin[i] = ^g_wrptr_sync[ADDR_W:i];
    end
    assign w_cnt_next = w_bin - w_b_next;
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_b_rdptr      <= '0;
            r_g_rdptr      <= '0;
            r_rd_count     <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_underflow    <= 1'b0;
        end else begin
            r_b_rdptr      <= w_b_next;
            r_g_rdptr      <= w_g_next;
            r_rd_count     <= w_cnt_next;
            r_empty        <= (g_wrptr_sync == w_g_next);
            r_almost_empty <= (w_cnt_next <= AE_V);
            r_underflow    <= rd_en & r_empty;
        end
    end
    assign b_rdptr      = r_b_rdptr;
    assign g_rdptr      = r_g_rdptr;
    assign rd_addr      = r_b_rdptr[ADDR_W-1:0];
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_count     = r_rd_count;
    assign underflow    = r_underflow;
endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// tb_rd_ptr_ctrl: directed self-checking bench for rd_ptr_ctrl with ADDR_W=4, AE_TH=2
module tb_rd_ptr_ctrl;
    logic       rd_clk, rd_rst, rd_en;
    logic [4:0] g_wrptr_sync, b_rdptr, g_rdptr, rd_count;
    logic [3:0] rd_addr;
    logic       empty, almost_empty, underflow;
    int checks = 0;
    int errors = 0;

    rd_ptr_ctrl #(.ADDR_W(4), .AE_TH(2)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .g_wrptr_sync(g_wrptr_sync),
        .b_rdptr(b_rdptr), .g_rdptr(g_rdptr), .rd_addr(rd_addr), .empty(empty),
        .almost_empty(almost_empty), .rd_count(rd_count), .underflow(underflow)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_b, exp_w, exp_cnt, prev_g, prev_b;
        logic       wrapped;
        rd_rst = 1'b1;
        rd_en = 1'b0;
        g_wrptr_sync = '0;
        tick();
        tick();
        chk("rst_b", b_rdptr, 0);
        chk("rst_empty", empty, 1);
        rd_rst = 1'b0;
        // reads in flight when reset hits mid-cycle
        g_wrptr_sync = gray(5'd5);
        rd_en = 1'b1;
        tick();
        chk("first_uf", underflow, 1);
        tick();
        tick();
        chk("pre_rst_b", b_rdptr, 2);
        #3;
        rd_rst = 1'b1;
        #1;
        chk("arst_b", b_rdptr, 0);
        chk("arst_g", g_rdptr, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_cnt", rd_count, 0);
        chk("arst_uf", underflow, 0);
        rd_en = 1'b0;
        tick();
        rd_rst = 1'b0;
        // fill and drain
        tick();
        chk("fill_cnt", rd_count, 5);
        chk("fill_empty", empty, 0);
        chk("fill_ae", almost_empty, 0);
        rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("drain_cnt", rd_count, 5 - i);
            chk("drain_ae", almost_empty, (i >= 3) ? 1 : 0);
            chk("drain_empty", empty, (i == 5) ? 1 : 0);
            chk("drain_b", b_rdptr, i);
        end
        chk("drain_addr", rd_addr, 5);
        chk("drain_uf", underflow, 0);
        // underflow: rd_en held while empty
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("uf_pulse", underflow, 1);
            chk("uf_hold_b", b_rdptr, 5);
            chk("uf_hold_g", g_rdptr, gray(5'd5));
        end
        rd_en = 1'b0;
        tick();
        chk("uf_clear", underflow, 0);
        chk("uf_after_b", b_rdptr, 5);
        // full count
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
        g_wrptr_sync = 5'b11000;
        tick();
        chk("full_cnt", rd_count, 16);
        chk("full_empty", empty, 0);
        chk("full_ae", almost_empty, 0);
        // wrap: writer stays ahead while 40 words are read back to back
        exp_b = 5'd0;
        exp_w = 5'd16;
        wrapped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 24) exp_w = exp_w + 5'd1;
            g_wrptr_sync = gray(exp_w);
            rd_en = 1'b1;
            prev_g = g_rdptr;
            prev_b = b_rdptr;
            tick();
            exp_b = exp_b + 5'd1;
            exp_cnt = exp_w - exp_b;
            if (prev_b == 5'd31 && b_rdptr == 5'd0) wrapped = 1'b1;
            chk("wrap_b", b_rdptr, exp_b);
            chk("wrap_g", g_rdptr, gray(exp_b));
            chk("wrap_ham", $countones(prev_g ^ g_rdptr), 1);
            chk("wrap_cnt", rd_count, (exp_w == exp_b) ? 0 : ((exp_cnt == 0) ? 16 : exp_cnt));
            chk("wrap_empty", empty, (exp_w == exp_b) ? 1 : 0);
        end
        chk("wrap_seen", wrapped, 1);
        // simultaneous read and write-pointer advance
        rd_en = 1'b0;
        g_wrptr_sync = gray(5'd11);
        tick();
        chk("sim_pre_cnt", rd_count, 3);
        chk("sim_pre_ae", almost_empty, 0);
        rd_en = 1'b1;
        g_wrptr_sync = gray(5'd12);
        tick();
        chk("sim_cnt", rd_count, 3);
        chk("sim_ae", almost_empty, 0);
        chk("sim_b", b_rdptr, 9);
        rd_en = 1'b0;
        tick();
        chk("sim_hold_b", b_rdptr, 9);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
